// File: rtl/uart_block_tx_sequencer.sv
// Streams a wide data block into a byte-wide UART transmitter, MSB byte first,
// timing each byte slot locally because the transmitter exposes no busy flag.
module uart_block_tx_sequencer #(
    parameter int NUM_BYTES    = 16,
    parameter int CLKS_PER_BIT = 866,
    parameter int HOLD_BITS    = 2,
    parameter int FRAME_BITS   = 13,
    localparam int IW          = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   blk_valid,
    input  logic [8*NUM_BYTES-1:0] blk_data,
    output logic                   blk_ready,
    output logic                   tx_transmit,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [IW-1:0]          byte_idx,
    output logic                   done
);

    localparam int SLOT_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int HOLD_CYCLES = HOLD_BITS * CLKS_PER_BIT;
    localparam int CW          = $clog2(SLOT_CYCLES);
    localparam int BW          = 8 * NUM_BYTES;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   blk_reg, blk_reg_n;
    logic [BW-1:0]   blk_shift;
    logic            tx_transmit_n;
    logic [7:0]      tx_data_n;
    logic            busy_n;
    logic [IW-1:0]   byte_idx_n;
    logic            done_n;

    // The block register shifts left one byte per slot, so the byte on air is always the top byte.
    assign blk_shift = blk_reg << 8;
    assign blk_ready = (state == IDLE);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        blk_reg_n     = blk_reg;
        tx_transmit_n = tx_transmit;
        tx_data_n     = tx_data;
        busy_n        = busy;
        byte_idx_n    = byte_idx;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                if (blk_valid) begin
                    blk_reg_n     = blk_data;
                    byte_idx_n    = '0;
                    busy_n        = 1'b1;
                    cnt_n         = '0;
                    tx_data_n     = blk_data[BW-1 -: 8];
                    tx_transmit_n = 1'b1;
                    state_n       = HOLD;
                end
            end

            HOLD: begin
                cnt_n = cnt + CW'(1);
                if (cnt == HOLD_LAST) begin
                    tx_transmit_n = 1'b0;
                    state_n       = WAIT;
                end
            end

            WAIT: begin
                if (cnt == SLOT_LAST) begin
                    cnt_n = '0;
                    if (byte_idx < IDX_LAST) begin
                        byte_idx_n    = byte_idx + IW'(1);
                        blk_reg_n     = blk_shift;
                        tx_data_n     = blk_shift[BW-1 -: 8];
                        tx_transmit_n = 1'b1;
                        state_n       = HOLD;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            blk_reg     <= '0;
            tx_transmit <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            byte_idx    <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            blk_reg     <= blk_reg_n;
            tx_transmit <= tx_transmit_n;
            tx_data     <= tx_data_n;
            busy        <= busy_n;
            byte_idx    <= byte_idx_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_block_tx_sequencer.sv
// Self-checking bench: a 4-byte and a 1-byte sequencer (4 clocks per bit) compared
// cycle by cycle against slot arithmetic, plus a transmitter-side byte collector.
module tb_uart_block_tx_sequencer;

    localparam int CPB   = 4;
    localparam int HBITS = 2;
    localparam int FBITS = 13;
    localparam int SLOT  = FBITS * CPB;
    localparam int HOLDC = HBITS * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        vA = 1'b0;
    logic [31:0] dA = '0;
    logic        rdyA, txA, busyA, doneA;
    logic [7:0]  tdA;
    logic [1:0]  idxA;

    logic        vB = 1'b0;
    logic [7:0]  dB = '0;
    logic        rdyB, txB, busyB, doneB;
    logic [7:0]  tdB;
    logic [0:0]  idxB;

    int tests = 0;
    int fails = 0;

    logic [7:0] qA[$];
    logic [7:0] qB[$];
    logic       prevTxA = 1'b0;
    logic       prevTxB = 1'b0;

    always #5 clk = ~clk;

    uart_block_tx_sequencer #(
        .NUM_BYTES(4), .CLKS_PER_BIT(CPB), .HOLD_BITS(HBITS), .FRAME_BITS(FBITS)
    ) dutA (
        .clk(clk), .reset(reset), .blk_valid(vA), .blk_data(dA), .blk_ready(rdyA),
        .tx_transmit(txA), .tx_data(tdA), .busy(busyA), .byte_idx(idxA), .done(doneA)
    );

    uart_block_tx_sequencer #(
        .NUM_BYTES(1), .CLKS_PER_BIT(CPB), .HOLD_BITS(HBITS), .FRAME_BITS(FBITS)
    ) dutB (
        .clk(clk), .reset(reset), .blk_valid(vB), .blk_data(dB), .blk_ready(rdyB),
        .tx_transmit(txB), .tx_data(tdB), .busy(busyB), .byte_idx(idxB), .done(doneB)
    );

    // Transmitter-side view: one byte is launched on each rising edge of tx_transmit.
    always @(negedge clk) begin
        if (txA && !prevTxA) qA.push_back(tdA);
        if (txB && !prevTxB) qB.push_back(tdB);
        prevTxA = txA;
        prevTxB = txB;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obsVec(input int sel);
        if (sel == 0) return {18'b0, txA, tdA, idxA, busyA, doneA, rdyA};
        return {18'b0, txB, tdB, 1'b0, idxB, busyB, doneB, rdyB};
    endfunction

    function automatic logic [7:0] byteOf(input logic [31:0] blk, input int n, input int j);
        logic [31:0] s;
        s = blk >> (8 * (n - 1 - j));
        return s[7:0];
    endfunction

    // Expected outputs k cycles after the first tx_transmit rise of a block.
    function automatic logic [31:0] expVec(input int n, input logic [31:0] blk, input int k);
        logic t, b, dn, r;
        logic [7:0] d;
        logic [1:0] ix;
        int j;
        if (k < n * SLOT) begin
            j  = k / SLOT;
            t  = ((k % SLOT) < HOLDC);
            d  = byteOf(blk, n, j);
            ix = 2'(j);
            b  = 1'b1; dn = 1'b0; r = 1'b0;
        end else begin
            t  = 1'b0;
            d  = byteOf(blk, n, n - 1);
            ix = 2'(n - 1);
            b  = 1'b0; dn = 1'b1; r = 1'b1;
        end
        return {18'b0, t, d, ix, b, dn, r};
    endfunction

    task automatic setInputs(input int sel, input logic v, input logic [31:0] d);
        if (sel == 0) begin
            vA = v; dA = d;
        end else begin
            vB = v; dB = d[7:0];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the done cycle, or at cycle abortAt.
    task automatic applyStimulus(input int sel, input logic [31:0] blk, input bit chain,
                                 input logic [31:0] nxt, input int abortAt);
        int n;
        logic [31:0] v;
        n = (sel == 0) ? 4 : 1;
        v = obsVec(sel);
        checkOutput($sformatf("ready%0d", sel), {31'b0, v[0]}, 32'h1);
        if (sel == 0) qA.delete(); else qB.delete();
        setInputs(sel, 1'b1, blk);
        @(negedge clk);
        for (int k = 0; k <= n * SLOT; k++) begin
            if (abortAt >= 0 && k == abortAt) return;
            checkOutput($sformatf("dut%0d k%0d", sel, k), obsVec(sel), expVec(n, blk, k));
            if (chain) setInputs(sel, 1'b1, nxt);
            else if (k < n * SLOT) setInputs(sel, 1'($urandom_range(0, 1)), $urandom);
            else setInputs(sel, 1'b0, $urandom);
            if (k < n * SLOT) @(negedge clk);
        end
        if (sel == 0) begin
            checkOutput("bytesA", qA.size(), n);
            for (int i = 0; i < n && i < qA.size(); i++)
                checkOutput($sformatf("byteA%0d", i), {24'b0, qA[i]}, {24'b0, byteOf(blk, n, i)});
            qA.delete();
        end else begin
            checkOutput("bytesB", qB.size(), n);
            for (int i = 0; i < n && i < qB.size(); i++)
                checkOutput($sformatf("byteB%0d", i), {24'b0, qB[i]}, {24'b0, byteOf(blk, n, i)});
            qB.delete();
        end
    endtask

    initial begin
        logic [31:0] cur, nxt;
        #2 reset = 1'b0;
        #1;
        checkOutput("resetA", obsVec(0), 32'h1);
        checkOutput("resetB", obsVec(1), 32'h1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idleA %0d", i), obsVec(0), 32'h1);
            checkOutput($sformatf("idleB %0d", i), obsVec(1), 32'h1);
            dA = $urandom;
            dB = 8'($urandom);
        end
        @(negedge clk);

        applyStimulus(0, 32'hA1B2C3D4, 1'b0, 32'h0, -1);
        @(negedge clk);

        cur = $urandom;
        applyStimulus(0, cur, 1'b1, 32'h11223344, -1);
        applyStimulus(0, 32'h11223344, 1'b0, 32'h0, -1);
        @(negedge clk);

        applyStimulus(1, 32'h5A, 1'b0, 32'h0, -1);
        cur = $urandom;
        applyStimulus(1, cur, 1'b1, 32'hC3, -1);
        applyStimulus(1, 32'hC3, 1'b0, 32'h0, -1);
        @(negedge clk);

        applyStimulus(0, $urandom, 1'b0, 32'h0, 2 * SLOT + 20);
        setInputs(0, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        checkOutput("midresetA", obsVec(0), 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("heldresetA", obsVec(0), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, $urandom, 1'b0, 32'h0, -1);

        cur = $urandom;
        for (int i = 0; i < 3; i++) begin
            nxt = $urandom;
            applyStimulus(0, cur, (i < 2), nxt, -1);
            cur = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_block_tx_sequencer.md
Name: uart_block_tx_sequencer

Overview:
Sequences the byte-wide UART transmitter so that a wide data block (e.g. a 128-bit cipher block) is sent as a stream of bytes, MSB byte first. It accepts one block per valid/ready handshake, drives the transmitter's transmit/data inputs, and times each byte slot itself, because the transmitter has no busy output. It sits between the crypto core's output register and the UART transmitter instance, in the same clock domain.

Parameters:
NUM_BYTES, 16, bytes per block; block width is 8*NUM_BYTES.
CLKS_PER_BIT, 866, clocks per baud tick; must match the transmitter's baud counter (0..865).
HOLD_BITS, 2, baud periods for which tx_transmit stays high per byte; legal range 2..8.
FRAME_BITS, 13, baud periods per byte slot, covering the hold time, 10 frame bits and margin; must be at least 12 and greater than HOLD_BITS.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
blk_valid  in  1  block available on blk_data
blk_data  in  8*NUM_BYTES  block; byte 0 = blk_data[8*NUM_BYTES-1 -: 8]
blk_ready  out  1  block accepted when blk_valid & blk_ready at rising clk
tx_transmit  out  1  to transmitter transmit input
tx_data  out  8  to transmitter data input
busy  out  1  high from acceptance until the last byte slot ends
byte_idx  out  clog2(NUM_BYTES) (min 1)  index of byte currently being sent
done  out  1  one-cycle pulse when the last byte slot of a block ends

Behaviour:
- Reset (async assert, sync deassert in the reset synchroniser upstream):
  - state=IDLE; tx_transmit=0; tx_data=0; busy=0; byte_idx=0; done=0.
  - Slot counter and block register cleared.
- Registered outputs: all outputs except blk_ready. blk_ready = (state==IDLE), combinational.
- Slot counter width is clog2(FRAME_BITS*CLKS_PER_BIT); it counts 0..FRAME_BITS*CLKS_PER_BIT-1 and then wraps.
- IDLE:
  - blk_ready=1.
  - On handshake: capture blk_data into the block register, byte_idx<=0, busy<=1, slot counter<=0, tx_data<=byte 0, tx_transmit<=1, go to HOLD.
  - tx_transmit therefore rises on the cycle after the handshake edge.
- HOLD:
  - tx_transmit=1 for exactly HOLD_BITS*CLKS_PER_BIT cycles.
  - It then drops to 0, and the state moves to WAIT (counter keeps running).
  - The hold guarantees at least one transmitter baud tick samples transmit. The hold ends before the transmitter can return to idle, so the transmitter never triggers twice.
- WAIT:
  - The state continues until the counter reaches FRAME_BITS*CLKS_PER_BIT-1.
  - Then, if byte_idx < NUM_BYTES-1: byte_idx++, tx_data<=next byte, tx_transmit<=1, counter<=0, go to HOLD.
  - Otherwise: busy<=0, done<=1 for one cycle, tx_data held, go to IDLE.
- Timing:
  - Each byte slot is exactly FRAME_BITS*CLKS_PER_BIT cycles.
  - Block duration, from the first tx_transmit rise to the done pulse, is NUM_BYTES*FRAME_BITS*CLKS_PER_BIT cycles.
  - The next block can be accepted in the same cycle done is high, because blk_ready is already 1.
- tx_data is stable for the whole slot and changes only on slot boundaries.
- blk_valid/blk_data are ignored while busy. The captured block is unaffected by blk_data changes after acceptance.
- NUM_BYTES=1: a single slot, then done.
- Reset mid-block:
  - Immediate return to the reset values; the remaining bytes are discarded.
  - The transmitter is reset by the same net, so no partial frame continues.
- No back-pressure from the transmitter exists. Correctness relies on CLKS_PER_BIT matching the transmitter baud counter.

Test Plan:
- CLKS_PER_BIT=4, HOLD_BITS=2, FRAME_BITS=13, NUM_BYTES=4; send 32'hA1B2C3D4 -> the transmitter model sees bytes A1,B2,C3,D4 in order; tx_transmit high 8 cycles per slot; slot = 52 cycles; done pulses once, 208 cycles after the first tx_transmit rise.
- Same parameters, with blk_valid held high and blk_data changed to 32'h11223344 while busy -> first block is sent unchanged; second block is accepted in the done cycle; its first tx_transmit rises the next cycle.
- Default parameters (866, 16 bytes), full transmitter in loop with a UART receiver model -> 16 bytes decoded; block time 16*13*866 = 180128 cycles; no duplicated or lost byte.
- Assert reset=0 during byte 2 of a 4-byte block -> outputs return to 0 and IDLE asynchronously; after release, blk_ready=1 and a new block is sent from byte 0.
- NUM_BYTES=1, CLKS_PER_BIT=4, byte 8'h5A -> one 52-cycle slot; tx_data=5A; done one cycle; byte_idx stays 0.
- blk_valid=0 for 100 cycles after reset -> tx_transmit, busy and done stay 0; blk_ready stays 1.
